// File: rtl/truth_table_sweeper.sv
// Clocked truth-table sweeper: walks every minterm, samples normal/reduced outputs, scores disagreements.
// Optional: TRUTH_TABLE_SWEEPER_STOP_ON_FAIL_EN ends the sweep at the first mismatching minterm.
module truth_table_sweeper #(
  parameter int N_VARS = 4,
  parameter int SETTLE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   s_normal,
  input  logic                   s_reduced,
  output logic [N_VARS-1:0]      vars,
  output logic [N_VARS-1:0]      index,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_VARS:0]        mismatch_count,
  output logic [N_VARS-1:0]      first_fail,
  output logic                   first_fail_valid,
  output logic [2**N_VARS-1:0]   table_normal
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

  localparam logic [3:0]        SETTLE_LD = 4'(SETTLE);
  localparam logic [N_VARS-1:0] LAST_V    = '1;
  localparam logic [N_VARS-1:0] ONE_V     = 1;
  localparam logic [N_VARS:0]   ONE_C     = 1;
  localparam state_t            FIRST_ST  = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;

  state_t                 state, state_nx;
  logic [3:0]             cnt, cnt_nx;
  logic [N_VARS-1:0]      vars_nx, ff_nx;
  logic                   busy_nx, done_nx, pass_nx, ffv_nx;
  logic [N_VARS:0]        mc_nx;
  logic [2**N_VARS-1:0]   tab_nx;
  logic                   miss, stop;

  // Case-inequality so an X/Z on either function output scores as a mismatch.
  assign miss  = (s_normal !== s_reduced);
  assign index = vars;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      vars             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      mismatch_count   <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
      table_normal     <= '0;
    end else begin
      state            <= state_nx;
      cnt              <= cnt_nx;
      vars             <= vars_nx;
      busy             <= busy_nx;
      done             <= done_nx;
      pass             <= pass_nx;
      mismatch_count   <= mc_nx;
      first_fail       <= ff_nx;
      first_fail_valid <= ffv_nx;
      table_normal     <= tab_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    vars_nx  = vars;
    busy_nx  = busy;
    done_nx  = done;
    pass_nx  = pass;
    mc_nx    = mismatch_count;
    ff_nx    = first_fail;
    ffv_nx   = first_fail_valid;
    tab_nx   = table_normal;
    stop     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mc_nx    = '0;
          ff_nx    = '0;
          ffv_nx   = 1'b0;
          tab_nx   = '0;
          done_nx  = 1'b0;
          pass_nx  = 1'b0;
          vars_nx  = '0;
          cnt_nx   = SETTLE_LD;
          busy_nx  = 1'b1;
          state_nx = FIRST_ST;
        end
      end
      ST_SETTLE: begin
        cnt_nx = cnt - 4'd1;
        if (cnt <= 4'd1) state_nx = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        tab_nx[vars] = s_normal;
        if (miss) begin
          mc_nx = mismatch_count + ONE_C;
          if (!first_fail_valid) begin
            ff_nx  = vars;
            ffv_nx = 1'b1;
          end
        end
`ifdef TRUTH_TABLE_SWEEPER_STOP_ON_FAIL_EN
        stop = (vars == LAST_V) || miss;
`else
        stop = (vars == LAST_V);
`endif
        if (stop) begin
          state_nx = ST_DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          pass_nx  = (mc_nx == '0);
        end else begin
          vars_nx  = vars + ONE_V;
          cnt_nx   = SETTLE_LD;
          state_nx = FIRST_ST;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: three instances (N=3/S=0, N=4/S=0, N=4/S=2) fed by boolean models.
module tb_truth_table_sweeper;

`ifdef TRUTH_TABLE_SWEEPER_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start3 = 1'b0, start4 = 1'b0, start4s = 1'b0, inj = 1'b0;

  logic [2:0]  v3, i3, ff3;
  logic        busy3, done3, pass3, ffv3, sn3, sr3;
  logic [3:0]  mc3;
  logic [7:0]  tab3;

  logic [3:0]  v4, i4, ff4;
  logic        busy4, done4, pass4, ffv4, sn4, sr4;
  logic [4:0]  mc4;
  logic [15:0] tab4;

  logic [3:0]  v4s, i4s, ff4s;
  logic        busy4s, done4s, pass4s, ffv4s, sn4s, sr4s;
  logic [4:0]  mc4s;
  logic [15:0] tab4s;

  // Unreduced SOP vs reduced form of x&(~z|~y).
  assign sn3 = (v3[2] & ~v3[1] & ~v3[0]) | (v3[2] & ~v3[1] & v3[0]) | (v3[2] & v3[1] & ~v3[0]);
  assign sr3 = v3[2] & (~v3[0] | ~v3[1]);
  // (x|y)&(x|~y)&(~y|~w|~z) vs x&~(y&w&z); inj flips the reduced output at minterms 5 and 12.
  assign sn4  = (v4[3] | v4[2]) & (v4[3] | ~v4[2]) & (~v4[2] | ~v4[1] | ~v4[0]);
  assign sr4  = (v4[3] & ~(v4[2] & v4[1] & v4[0])) ^ (inj && (v4 == 4'd5 || v4 == 4'd12));
  assign sn4s = (v4s[3] | v4s[2]) & (v4s[3] | ~v4s[2]) & (~v4s[2] | ~v4s[1] | ~v4s[0]);
  assign sr4s = v4s[3] & ~(v4s[2] & v4s[1] & v4s[0]);

  truth_table_sweeper #(.N_VARS(3), .SETTLE(0)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .s_normal(sn3), .s_reduced(sr3),
    .vars(v3), .index(i3), .busy(busy3), .done(done3), .pass(pass3),
    .mismatch_count(mc3), .first_fail(ff3), .first_fail_valid(ffv3), .table_normal(tab3));

  truth_table_sweeper #(.N_VARS(4), .SETTLE(0)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .s_normal(sn4), .s_reduced(sr4),
    .vars(v4), .index(i4), .busy(busy4), .done(done4), .pass(pass4),
    .mismatch_count(mc4), .first_fail(ff4), .first_fail_valid(ffv4), .table_normal(tab4));

  truth_table_sweeper #(.N_VARS(4), .SETTLE(2)) dut4s (
    .clk(clk), .rst(rst), .start(start4s), .s_normal(sn4s), .s_reduced(sr4s),
    .vars(v4s), .index(i4s), .busy(busy4s), .done(done4s), .pass(pass4s),
    .mismatch_count(mc4s), .first_fail(ff4s), .first_fail_valid(ffv4s), .table_normal(tab4s));

  // Selected-instance view so one set of tasks serves all three instances.
  int          sel = 1;
  logic [15:0] o_vars, o_index, o_table, o_ff, o_cnt;
  logic        o_busy, o_done, o_pass, o_ffv;

  always_comb begin
    o_vars = '0; o_index = '0; o_table = '0; o_ff = '0; o_cnt = '0;
    o_busy = 1'b0; o_done = 1'b0; o_pass = 1'b0; o_ffv = 1'b0;
    case (sel)
      0: begin
        o_vars = 16'(v3); o_index = 16'(i3); o_table = 16'(tab3); o_ff = 16'(ff3); o_cnt = 16'(mc3);
        o_busy = busy3; o_done = done3; o_pass = pass3; o_ffv = ffv3;
      end
      1: begin
        o_vars = 16'(v4); o_index = 16'(i4); o_table = tab4; o_ff = 16'(ff4); o_cnt = 16'(mc4);
        o_busy = busy4; o_done = done4; o_pass = pass4; o_ffv = ffv4;
      end
      default: begin
        o_vars = 16'(v4s); o_index = 16'(i4s); o_table = tab4s; o_ff = 16'(ff4s); o_cnt = 16'(mc4s);
        o_busy = busy4s; o_done = done4s; o_pass = pass4s; o_ffv = ffv4s;
      end
    endcase
  end

  typedef struct {
    logic [15:0] tab;
    int          cnt;
    int          ff;
    bit          ffv;
    bit          pass;
    int          cycles;
    int          last;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  function automatic bit f3(int m);
    bit x, y, z;
    x = m[2]; y = m[1]; z = m[0];
    return x & (~z | ~y);
  endfunction

  function automatic bit f4(int m);
    bit x, y, w, z;
    x = m[3]; y = m[2]; w = m[1]; z = m[0];
    return x & ~(y & w & z);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      passed++;
  endtask

  task automatic setStart(input int which, input logic val);
    case (which)
      0:       start3  = val;
      1:       start4  = val;
      default: start4s = val;
    endcase
  endtask

  task automatic applyStimulus(input int which, input bit fault, input int pulse_at);
    exp_t e, g;
    int nv, st, cyc, verr, ev;
    bit n, r;
    nv = (which == 0) ? 3 : 4;
    st = (which == 2) ? 2 : 0;
    e.tab = '0; e.cnt = 0; e.ff = 0; e.ffv = 0; e.last = 0;
    for (int m = 0; m < (1 << nv); m++) begin
      n = (nv == 3) ? f3(m) : f4(m);
      r = n ^ (fault && (m == 5 || m == 12));
      e.tab[m] = n;
      e.last = m;
      if (n != r) begin
        e.cnt++;
        if (!e.ffv) begin
          e.ff = m;
          e.ffv = 1'b1;
        end
        if (STOP) break;
      end
    end
    e.pass   = (e.cnt == 0);
    e.cycles = (e.last + 1) * (st + 1);
    sb.push_back(e);

    sel = which;
    inj = fault;
    @(negedge clk);
    setStart(which, 1'b1);
    @(posedge clk);
    #1;
    setStart(which, 1'b0);
    checkOutput("go_busy", 32'(o_busy), 32'd1);
    checkOutput("go_done_clr", 32'(o_done), 32'd0);
    checkOutput("go_cnt_clr", 32'(o_cnt), 32'd0);
    checkOutput("go_table_clr", 32'(o_table), 32'd0);
    checkOutput("go_ffv_clr", 32'(o_ffv), 32'd0);

    cyc = 0;
    verr = 0;
    while (!o_done && cyc < 400) begin
      setStart(which, (pulse_at > 0 && cyc == pulse_at) ? 1'b1 : 1'b0);
      @(posedge clk);
      #1;
      cyc++;
      ev = o_done ? e.last : cyc / (st + 1);
      if (o_vars !== 16'(ev)) verr++;
    end
    setStart(which, 1'b0);
    checkOutput("done_cycles", 32'(cyc), 32'(e.cycles));
    checkOutput("vars_seq", 32'(verr), 32'd0);

    if (sb.size() == 0) begin
      checkOutput("sb_empty", 32'd1, 32'd0);
    end else begin
      g = sb.pop_front();
      checkOutput("table_normal", 32'(o_table), 32'(g.tab));
      checkOutput("mismatch_count", 32'(o_cnt), 32'(g.cnt));
      checkOutput("first_fail_valid", 32'(o_ffv), 32'(g.ffv));
      if (g.ffv) checkOutput("first_fail", 32'(o_ff), 32'(g.ff));
      checkOutput("pass", 32'(o_pass), 32'(g.pass));
      checkOutput("final_vars", 32'(o_vars), 32'(g.last));
      checkOutput("index_eq", 32'(o_index), 32'(g.last));
      checkOutput("busy_end", 32'(o_busy), 32'd0);
    end
    @(posedge clk);
    #1;
    checkOutput("done_hold", 32'(o_done), 32'd1);
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_vars"}, 32'(o_vars), 32'd0);
    checkOutput({tag, "_busy"}, 32'(o_busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(o_done), 32'd0);
    checkOutput({tag, "_pass"}, 32'(o_pass), 32'd0);
    checkOutput({tag, "_cnt"}, 32'(o_cnt), 32'd0);
    checkOutput({tag, "_ff"}, 32'(o_ff), 32'd0);
    checkOutput({tag, "_ffv"}, 32'(o_ffv), 32'd0);
    checkOutput({tag, "_table"}, 32'(o_table), 32'd0);
  endtask

  // Faulty sweep on dut4 aborted by a two-cycle reset pulse starting at cycle 7.
  task automatic resetTest();
    sel = 1;
    inj = 1'b1;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    checkOutput("pre_rst_cnt", 32'(o_cnt), 32'd1);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    checkZero("mid_rst");
    @(posedge clk);
    #1;
    checkOutput("post_rst_idle", 32'(o_busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    sel = 1;
    checkZero("reset");
    $display("[TB] N_VARS=3 SETTLE=0 clean sweep");
    applyStimulus(0, 1'b0, 0);
    $display("[TB] N_VARS=4 SETTLE=0 clean sweep");
    applyStimulus(1, 1'b0, 0);
    $display("[TB] N_VARS=4 faults at minterms 5 and 12, restart from DONE");
    applyStimulus(1, 1'b1, 0);
    applyStimulus(1, 1'b0, 0);
    $display("[TB] N_VARS=4 SETTLE=2 with ignored start at cycle 10");
    applyStimulus(2, 1'b0, 10);
    $display("[TB] reset mid-sweep then clean sweep");
    resetTest();
    applyStimulus(1, 1'b0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
